// File: rtl/karatsuba_pkg.sv
// -----------------------------------------------------------------------------
// karatsuba_pkg
// Shared types and helpers for the one-level Karatsuba multiplier.
//   state_t      : controller states.
//   kara_latency : cycles from the accept edge to the first out_valid cycle,
//                  for an operand width w and a PARALLEL setting.
// -----------------------------------------------------------------------------
package karatsuba_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START0,
    WAIT0,
    START1,
    WAIT1,
    START2,
    WAIT2,
    COMBINE,
    OUT
  } state_t;

  // Sub-multiplier width is the upper half plus one bit for the half-sums.
  function automatic int kara_latency(input int w, input int parallel);
    int n;
    n = (w - w / 2) + 1;
    return (parallel != 0) ? (n + 3) : (3 * n + 5);
  endfunction

endpackage

// File: rtl/seq_mult_u.sv
// -----------------------------------------------------------------------------
// seq_mult_u
// N x N -> 2N unsigned shift-add multiplier, one multiplier bit per cycle.
// The start edge loads the operands and already consumes bit 0, so o_done
// pulses for exactly one cycle N cycles after the start cycle. o_p holds the
// result until the next start; a start while running restarts it.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        one-cycle start request
//   i_a, i_b       N-bit operands (sampled on start)
//   o_p            2N-bit product
//   o_done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_mult_u #(
  parameter int N = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p,
  output logic           o_done
);

  // Counts the N-1 remaining bits after the start edge.
  localparam int CW = $clog2(N);

  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_done;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= i_b[0] ? {{N{1'b0}}, i_a} : '0;
        r_mcand  <= {{(N-1){1'b0}}, i_a, 1'b0};
        r_mplier <= i_b >> 1;
        r_cnt    <= CW'(N - 1);
      end else if (r_cnt != '0) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_p    = r_acc;
  assign o_done = r_done;

endmodule

// File: rtl/karatsuba_mul_hs.sv
// -----------------------------------------------------------------------------
// karatsuba_mul_hs
// One-level Karatsuba multiplier, W x W -> 2W exact product, unsigned or
// two's complement, with valid/ready handshakes on both sides.
// Partial products z0 = lo*lo, z1 = hi*hi, z2 = (a_hi+a_lo)*(b_hi+b_lo) come
// from seq_mult_u: three concurrent instances (PARALLEL=1) or one shared
// instance walked through z0, z1, z2 (PARALLEL=0).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   a, b                  W-bit operands
//   out_valid / out_ready result handshake
//   p                     2W-bit product, held after the handshake
//   busy                  high in every state except IDLE
// -----------------------------------------------------------------------------
module karatsuba_mul_hs
  import karatsuba_pkg::*;
#(
  parameter int W        = 34,
  parameter int SIGNED   = 0,
  parameter int PARALLEL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;
  localparam int N  = HI + 1;
  localparam int PW = 2 * W;

  state_t                 r_state;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic                   r_neg;
  logic [2:0][2*N-1:0]    r_z;
  logic [2:0]             r_seen;
  logic [PW-1:0]          r_p;
  logic                   r_out_valid;

  // Magnitudes and sign of the incoming operands; |-2^(W-1)| fits in W bits.
  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;
  logic          w_neg;

  assign w_abs_a = (SIGNED != 0 && a[W-1]) ? (~a + W'(1)) : a;
  assign w_abs_b = (SIGNED != 0 && b[W-1]) ? (~b + W'(1)) : b;
  assign w_neg   = (SIGNED != 0) ? (a[W-1] ^ b[W-1]) : 1'b0;

  // Halves zero-extended to N bits; the half-sums cannot overflow N bits.
  logic [2:0][N-1:0] w_op_a;
  logic [2:0][N-1:0] w_op_b;

  assign w_op_a[0] = N'(r_a[LO-1:0]);
  assign w_op_a[1] = N'(r_a[W-1:LO]);
  assign w_op_a[2] = w_op_a[0] + w_op_a[1];
  assign w_op_b[0] = N'(r_b[LO-1:0]);
  assign w_op_b[1] = N'(r_b[W-1:LO]);
  assign w_op_b[2] = w_op_b[0] + w_op_b[1];

  // Per-product result and done, whichever way the multipliers are built.
  logic [2:0][2*N-1:0] w_pp;
  logic [2:0]          w_done;

  generate
    if (PARALLEL != 0) begin : g_par
      logic w_start;
      assign w_start = (r_state == START0);
      for (genvar k = 0; k < 3; k++) begin : g_mul
        seq_mult_u #(.N(N)) u_mul (
          .clk     (clk),
          .rst     (rst),
          .i_start (w_start),
          .i_a     (w_op_a[k]),
          .i_b     (w_op_b[k]),
          .o_p     (w_pp[k]),
          .o_done  (w_done[k])
        );
      end
    end else begin : g_ser
      logic           w_start;
      logic [N-1:0]   w_mul_a;
      logic [N-1:0]   w_mul_b;
      logic [2*N-1:0] w_mul_p;
      logic           w_mul_done;

      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      always_comb begin
        w_mul_a = w_op_a[2];
        w_mul_b = w_op_b[2];
        case (r_state)
          START0, WAIT0: begin w_mul_a = w_op_a[0]; w_mul_b = w_op_b[0]; end
          START1, WAIT1: begin w_mul_a = w_op_a[1]; w_mul_b = w_op_b[1]; end
          default: ;
        endcase
      end

      assign w_start = (r_state == START0) || (r_state == START1) ||
                       (r_state == START2);

      seq_mult_u #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_p     (w_mul_p),
        .o_done  (w_mul_done)
      );

      // The shared done is routed to the z register owned by the wait state.
      assign w_pp   = {3{w_mul_p}};
      assign w_done = {r_state == WAIT2, r_state == WAIT1, r_state == WAIT0} &
                      {3{w_mul_done}};
    end
  endgenerate

  // Combine. mid = a_hi*b_lo + a_lo*b_hi is never negative. The exact product
  // is below 2^(2W), so modular arithmetic at 2W bits loses nothing.
  logic [2*N-1:0] w_mid;
  logic [PW-1:0]  w_prod;
  logic [PW-1:0]  w_p_next;

  assign w_mid    = r_z[2] - r_z[1] - r_z[0];
  assign w_prod   = (PW'(r_z[1]) << (2 * LO)) + (PW'(w_mid) << LO) + PW'(r_z[0]);
  assign w_p_next = r_neg ? (~w_prod + PW'(1)) : w_prod;

  // NOTE: every register here is a plain flop, so all of them are reset;
  // an abort therefore leaves no stale result or pending done behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_neg       <= 1'b0;
      r_z         <= '0;
      r_seen      <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_done[k]) begin
          r_z[k]    <= w_pp[k];
          r_seen[k] <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg   <= w_neg;
            r_seen  <= '0;
            r_state <= START0;
          end
        end
        START0: r_state <= WAIT0;
        WAIT0: begin
          // Parallel mode leaves WAIT0 only once all three z registers are
          // loaded; serial mode chains straight into the next product.
          if (PARALLEL != 0) begin
            if (r_seen == 3'b111) r_state <= COMBINE;
          end else if (w_done[0]) begin
            r_state <= START1;
          end
        end
        START1: r_state <= WAIT1;
        WAIT1:  if (w_done[1]) r_state <= START2;
        START2: r_state <= WAIT2;
        WAIT2:  if (r_seen == 3'b111) r_state <= COMBINE;
        COMBINE: begin
          r_p         <= w_p_next;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule

// File: tb/tb_karatsuba_mul_hs.sv
// -----------------------------------------------------------------------------
// tb_karatsuba_mul_hs
// Five configurations of karatsuba_mul_hs share one stimulus bus; sel picks
// the one being driven and observed. Expected products come from a plain
// wide-integer multiply of the sign/zero-extended operands.
// -----------------------------------------------------------------------------
module tb_karatsuba_mul_hs;
  import karatsuba_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [33:0] ta;
  logic [33:0] tb;
  logic [2:0]  sel;

  logic [4:0]  ivs, ovs, irs, bzs;
  logic [67:0] p0, p1;
  logic [65:0] p2;
  logic [7:0]  p3, p4;

  logic        cur_ov, cur_ir, cur_bz;
  logic [67:0] cur_p;

  logic [67:0] exp_p;
  logic        exp_pending;
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 5; k++) ivs[k] = in_valid && (sel == 3'(k));
  end

  always_comb begin
    cur_ov = ovs[sel];
    cur_ir = irs[sel];
    cur_bz = bzs[sel];
    case (sel)
      3'd0:    cur_p = p0;
      3'd1:    cur_p = p1;
      3'd2:    cur_p = 68'(p2);
      3'd3:    cur_p = 68'(p3);
      default: cur_p = 68'(p4);
    endcase
  end

  karatsuba_mul_hs #(.W(34), .SIGNED(0), .PARALLEL(1)) u_u34p (
    .clk(clk), .rst(rst), .in_valid(ivs[0]), .in_ready(irs[0]), .a(ta), .b(tb),
    .out_valid(ovs[0]), .out_ready(out_ready), .p(p0), .busy(bzs[0]));
  karatsuba_mul_hs #(.W(34), .SIGNED(1), .PARALLEL(1)) u_s34p (
    .clk(clk), .rst(rst), .in_valid(ivs[1]), .in_ready(irs[1]), .a(ta), .b(tb),
    .out_valid(ovs[1]), .out_ready(out_ready), .p(p1), .busy(bzs[1]));
  karatsuba_mul_hs #(.W(33), .SIGNED(0), .PARALLEL(0)) u_u33s (
    .clk(clk), .rst(rst), .in_valid(ivs[2]), .in_ready(irs[2]), .a(ta[32:0]),
    .b(tb[32:0]), .out_valid(ovs[2]), .out_ready(out_ready), .p(p2), .busy(bzs[2]));
  karatsuba_mul_hs #(.W(4), .SIGNED(0), .PARALLEL(1)) u_u4p (
    .clk(clk), .rst(rst), .in_valid(ivs[3]), .in_ready(irs[3]), .a(ta[3:0]),
    .b(tb[3:0]), .out_valid(ovs[3]), .out_ready(out_ready), .p(p3), .busy(bzs[3]));
  karatsuba_mul_hs #(.W(4), .SIGNED(1), .PARALLEL(1)) u_s4p (
    .clk(clk), .rst(rst), .in_valid(ivs[4]), .in_ready(irs[4]), .a(ta[3:0]),
    .b(tb[3:0]), .out_valid(ovs[4]), .out_ready(out_ready), .p(p4), .busy(bzs[4]));

  function automatic int cfg_w(input logic [2:0] s);
    case (s)
      3'd0, 3'd1: return 34;
      3'd2:       return 33;
      default:    return 4;
    endcase
  endfunction

  function automatic bit cfg_sgn(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd4);
  endfunction

  function automatic int cfg_par(input logic [2:0] s);
    return (s == 3'd2) ? 0 : 1;
  endfunction

  // Reference: extend both operands to 136 bits, multiply, keep 2w bits.
  function automatic logic [67:0] model(input int w, input bit sgn,
                                        input logic [33:0] x, input logic [33:0] y);
    logic        [135:0] m;
    logic signed [135:0] xa, ya, pr;
    m  = (136'd1 << w) - 136'd1;
    xa = {102'd0, x} & m;
    ya = {102'd0, y} & m;
    if (sgn && xa[w-1]) xa = xa | ~m;
    if (sgn && ya[w-1]) ya = ya | ~m;
    pr = xa * ya;
    pr = pr & ((136'd1 << (2 * w)) - 136'd1);
    return pr[67:0];
  endfunction

  function automatic logic [33:0] rnd34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[33:0];
  endfunction

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s (sel=%0d t=%0t): got %0h, want %0h", nm, sel, $time, act, expv);
    end
  endtask

  // Output compare: every cycle a product is presented it must be owed and correct.
  always @(negedge clk) begin
    if (!rst && cur_ov) begin
      check("p_vs_model", cur_p, exp_p);
      check("valid_owed", 68'(exp_pending), 68'd1);
    end
  end

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cur_ov) begin
        lat = c;
        break;
      end
    end
  endtask

  // One operation with out_ready high; called and returning at a negedge.
  task automatic do_op(input logic [33:0] x, input logic [33:0] y,
                       input logic [67:0] expv, output int lat);
    exp_p       = expv;
    exp_pending = 1'b1;
    ta          = x;
    tb          = y;
    in_valid    = 1'b1;
    check("in_ready_idle", 68'(cur_ir), 68'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("latency", 68'(lat), 68'(kara_latency(cfg_w(sel), cfg_par(sel))));
    if (lat >= 0) begin
      @(posedge clk);
      #1 exp_pending = 1'b0;
      @(negedge clk);
      check("valid_pulse", 68'(cur_ov), 68'd0);
      check("in_ready_back", 68'(cur_ir), 68'd1);
    end else begin
      exp_pending = 1'b0;
    end
  endtask

  task automatic do_model_op(input logic [33:0] x, input logic [33:0] y);
    int lat;
    do_op(x, y, model(cfg_w(sel), cfg_sgn(sel), x, y), lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [33:0] x, y;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ta          = '0;
    tb          = '0;
    sel         = 3'd0;
    exp_p       = '0;
    exp_pending = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of every configuration.
    for (int k = 0; k < 5; k++) begin
      sel = 3'(k);
      #1;
      check("rst_out_valid", 68'(cur_ov), 68'd0);
      check("rst_p",         cur_p,       68'd0);
      check("rst_in_ready",  68'(cur_ir), 68'd1);
      check("rst_busy",      68'(cur_bz), 68'd0);
    end
    @(negedge clk);

    // Pin the reference model and latency helper with hand-computed values.
    check("model_max_u34", model(34, 1'b0, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF),
          68'hF_FFFF_FFF8_0000_0001);
    check("model_m5x7_s34", model(34, 1'b1, 34'h3_FFFF_FFFB, 34'd7),
          68'hF_FFFF_FFFF_FFFF_FFDD);
    check("model_min_s34", model(34, 1'b1, 34'h2_0000_0000, 34'h2_0000_0000),
          68'h4_0000_0000_0000_0000);
    check("lat_fn_par", 68'(kara_latency(34, 1)), 68'd21);
    check("lat_fn_ser", 68'(kara_latency(33, 0)), 68'd59);

    // Unsigned, W=34, parallel.
    sel = 3'd0;
    #1;
    do_op(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 68'hF_FFFF_FFF8_0000_0001, lat);
    check("lat_max_21", 68'(lat), 68'd21);
    do_op(34'd0, rnd34(), 68'd0, lat);
    do_op(rnd34(), 34'd0, 68'd0, lat);
    do_op(34'd1, 34'h3_FFFF_FFFF, 68'h3_FFFF_FFFF, lat);
    for (int i = 0; i < 40; i++) do_model_op(rnd34(), rnd34());

    // Backpressure: hold out_ready low for 10 cycles while poking in_valid.
    x           = rnd34();
    y           = rnd34();
    exp_p       = model(34, 1'b0, x, y);
    exp_pending = 1'b1;
    ta          = x;
    tb          = y;
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 68'(lat), 68'd21);
    for (int i = 0; i < 10; i++) begin
      ta       = rnd34();
      tb       = rnd34();
      in_valid = 1'b1;
      check("bp_valid_held", 68'(cur_ov), 68'd1);
      check("bp_in_ready",   68'(cur_ir), 68'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_valid_last", 68'(cur_ov), 68'd1);
    @(posedge clk);
    #1 exp_pending = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 68'(cur_ov), 68'd0);
    check("bp_release_ready", 68'(cur_ir), 68'd1);
    check("bp_release_busy",  68'(cur_bz), 68'd0);
    check("bp_p_kept",        cur_p,       exp_p);
    repeat (8) @(negedge clk);
    check("bp_not_queued", 68'(cur_bz), 68'd0);

    // Signed, W=34, parallel.
    sel = 3'd1;
    #1;
    @(negedge clk);
    do_op(34'h2_0000_0000, 34'h2_0000_0000, 68'h4_0000_0000_0000_0000, lat);
    do_op(34'h3_FFFF_FFFB, 34'd7, 68'hF_FFFF_FFFF_FFFF_FFDD, lat);
    do_op(34'h2_0000_0000, 34'd1, 68'hF_FFFF_FFFE_0000_0000, lat);
    for (int i = 0; i < 40; i++) do_model_op(rnd34(), rnd34());

    // Unsigned, W=33, serial: abort in WAIT1, then normal traffic.
    sel = 3'd2;
    #1;
    @(negedge clk);
    exp_p       = '0;
    exp_pending = 1'b0;
    ta          = 34'h1_2345_6789;
    tb          = 34'h0_ABCD_EF01;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 68'(cur_bz), 68'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 68'(cur_ov), 68'd0);
    check("abort_p",         cur_p,       68'd0);
    check("abort_in_ready",  68'(cur_ir), 68'd1);
    check("abort_busy_low",  68'(cur_bz), 68'd0);
    repeat (80) @(negedge clk);
    do_op(34'd3, 34'd4, 68'd12, lat);
    check("lat_ser_59", 68'(lat), 68'd59);
    do_op(34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF, 68'h3_FFFF_FFFC_0000_0001, lat);
    for (int i = 0; i < 300; i++) do_model_op(rnd34() & 34'h1_FFFF_FFFF,
                                              rnd34() & 34'h1_FFFF_FFFF);

    // W=4 exhaustive, unsigned then signed.
    for (int s = 3; s <= 4; s++) begin
      sel = 3'(s);
      #1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) do_model_op(34'(i), 34'(j));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
